// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register indices, field positions, exception codes and register packing
package cp0_pkg;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC = 5'd14;
  localparam logic [4:0] CP0_PRID = 5'd15;
  localparam int SR_IE = 0;
  localparam int SR_EXL = 1;
  localparam int IM_LO = 10;
  localparam int IP_LO = 10;
  localparam int EXC_LO = 2;
  localparam int CAUSE_TI = 30;
  localparam int CAUSE_BD = 31;
  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI = 5'd10,
    EXC_OV = 5'd12
  } exc_code_e;
  function automatic logic [31:0] sr_word(input logic [5:0] im, input logic exl, input logic ie);
    return {16'b0, im, 8'b0, exl, ie};
  endfunction
  function automatic logic [31:0] cause_word(input logic bd, input logic ti, input logic [5:0] ip,
                                             input logic [4:0] code);
    return {bd, ti, 14'b0, ip, 3'b0, code, 2'b0};
  endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: prescaled Count/Compare timer with a sticky match flag
module cp0_timer #(
  parameter int TIMER_EN = 1,
  parameter int COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  logic [7:0] presc;
  logic [31:0] count_q, compare_q;
  logic ti_q, wrap;
  assign wrap = presc == 8'(COUNT_DIV - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      count_q <= '0;
      compare_q <= '0;
      ti_q <= 1'b0;
    end else begin
      presc <= (count_we || wrap) ? '0 : presc + 8'd1;
      count_q <= count_we ? wdata : count_q + {31'b0, wrap};
      if (compare_we) compare_q <= wdata;
      ti_q <= !compare_we && (ti_q || (wrap && !count_we && count_q + 32'd1 == compare_q));
    end
  end
  assign count = TIMER_EN != 0 ? count_q : '0;
  assign compare = TIMER_EN != 0 ? compare_q : '0;
  assign ti = TIMER_EN != 0 && ti_q;
endmodule

// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: CP0 with SR/Cause/EPC/BadVAddr/PRId, Count/Compare timer and
// interrupt/exception arbitration into a single flush request
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter int NUM_HWINT = 6,
  parameter int TIMER_EN = 1,
  parameter int COUNT_DIV = 1,
  parameter logic [31:0] PRID_VAL = 32'h0000_0008
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [4:0]           CP0Add,
  input  logic [31:0]          CP0In,
  output logic [31:0]          CP0Out,
  input  logic [31:0]          VPC,
  input  logic                 BDIn,
  input  logic [4:0]           ExcCodeIn,
  input  logic [31:0]          BadVAddrIn,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic [31:0]          EPCOut,
  output logic                 TimerIRQ,
  output logic                 Req
);
  logic [5:0] im, ip_q, ip_live, hw;
  logic exl, ie, bd, ti, int_req, exc_req, req, wr;
  logic [4:0] exc_code;
  logic [31:0] epc, badvaddr, count, compare, rd;
  assign hw = 6'(HWInt);
  // legal configurations never drive hw[5] together with the timer
  assign ip_live = TIMER_EN != 0 ? {hw[5] | ti, hw[4:0]} : hw;
  assign int_req = |(ip_live & im) && ie && !exl;
  assign exc_req = ExcCodeIn != EXC_INT && !exl;
  assign req = int_req || exc_req;
  assign wr = en && !req;
  cp0_timer #(.TIMER_EN(TIMER_EN), .COUNT_DIV(COUNT_DIV)) u_timer (
    .clk(clk),
    .reset(reset),
    .count_we(wr && CP0Add == CP0_COUNT),
    .compare_we(wr && CP0Add == CP0_COMPARE),
    .wdata(CP0In),
    .count(count),
    .compare(compare),
    .ti(ti)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im <= '0;
      exl <= 1'b0;
      ie <= 1'b0;
      bd <= 1'b0;
      ip_q <= '0;
      exc_code <= '0;
      epc <= '0;
      badvaddr <= '0;
    end else begin
      ip_q <= ip_live;
      if (req) begin
        exl <= 1'b1;
        epc <= {(BDIn ? VPC - 32'd4 : VPC) >> 2, 2'b00};
        bd <= BDIn;
        exc_code <= int_req ? EXC_INT : ExcCodeIn;
        if (!int_req && (ExcCodeIn == EXC_ADEL || ExcCodeIn == EXC_ADES)) badvaddr <= BadVAddrIn;
      end else begin
        if (en && CP0Add == CP0_SR) begin
          im <= CP0In[IM_LO +: 6];
          exl <= CP0In[SR_EXL];
          ie <= CP0In[SR_IE];
        end
        if (en && CP0Add == CP0_EPC) epc <= {CP0In[31:2], 2'b00};
        if (EXLClr) exl <= 1'b0;
      end
    end
  end
  always_comb begin
    rd = '0;
    case (CP0Add)
      CP0_BADVADDR: rd = badvaddr;
      CP0_COUNT: rd = count;
      CP0_COMPARE: rd = compare;
      CP0_SR: rd = sr_word(im, exl, ie);
      CP0_CAUSE: rd = cause_word(bd, ti, ip_q, exc_code);
      CP0_EPC: rd = epc;
      CP0_PRID: rd = PRID_VAL;
      default: rd = '0;
    endcase
  end
  assign CP0Out = reset ? rd : '0;
  assign EPCOut = epc;
  assign TimerIRQ = ti;
  assign Req = reset && req;
endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// tb_cp0_irq_ctrl: directed stimulus checked against a behavioural CP0 model every cycle
module tb_cp0_irq_ctrl;
  localparam int DIV = 2;
  logic clk, reset, en, BDIn, EXLClr, TimerIRQ, Req;
  logic [4:0] CP0Add, ExcCodeIn, HWInt;
  logic [31:0] CP0In, CP0Out, VPC, BadVAddrIn, EPCOut;
  int n_err = 0, n_chk = 0;

  cp0_irq_ctrl #(.NUM_HWINT(5), .TIMER_EN(1), .COUNT_DIV(DIV), .PRID_VAL(32'h0000_0008)) dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In), .CP0Out(CP0Out),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .BadVAddrIn(BadVAddrIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .EPCOut(EPCOut), .TimerIRQ(TimerIRQ), .Req(Req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] m_sr = 0, m_epc = 0, m_bad = 0, m_count = 0, m_cmp = 0;
  logic m_bd = 0, m_ti = 0, t_int, t_exc, t_wr;
  logic [4:0] m_code = 0;
  logic [5:0] m_ipq = 0;
  int m_phase = 0;

  function automatic logic [5:0] live_ip();
    return {m_ti, HWInt};
  endfunction
  function automatic logic m_int();
    return (|(live_ip() & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction
  function automatic logic m_exc();
    return ExcCodeIn != 5'd0 && !m_sr[1];
  endfunction
  function automatic logic exp_req();
    return reset && (m_int() || m_exc());
  endfunction
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!reset) return 32'd0;
    case (a)
      5'd8: return m_bad;
      5'd9: return m_count;
      5'd11: return m_cmp;
      5'd12: return m_sr;
      5'd13: return {m_bd, m_ti, 14'b0, m_ipq, 3'b0, m_code, 2'b0};
      5'd14: return m_epc;
      5'd15: return 32'h0000_0008;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sr = 0; m_epc = 0; m_bad = 0; m_count = 0; m_cmp = 0;
      m_bd = 0; m_ti = 0; m_code = 0; m_ipq = 0; m_phase = 0;
    end else begin
      t_int = m_int();
      t_exc = m_exc();
      t_wr = en && !(t_int || t_exc);
      m_ipq = live_ip();
      if (t_int || t_exc) begin
        m_sr[1] = 1'b1;
        m_epc = (BDIn ? VPC - 32'd4 : VPC) & ~32'd3;
        m_bd = BDIn;
        m_code = t_int ? 5'd0 : ExcCodeIn;
        if (!t_int && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5)) m_bad = BadVAddrIn;
      end else begin
        if (en && CP0Add == 5'd12) m_sr = CP0In & 32'h0000_FC03;
        if (en && CP0Add == 5'd14) m_epc = CP0In & ~32'd3;
        if (EXLClr) m_sr[1] = 1'b0;
      end
      if (t_wr && CP0Add == 5'd9) begin
        m_count = CP0In;
        m_phase = 0;
      end else begin
        m_phase++;
        if (m_phase == DIV) begin
          m_phase = 0;
          m_count++;
          if (m_count == m_cmp) m_ti = 1'b1;
        end
      end
      if (t_wr && CP0Add == 5'd11) begin
        m_cmp = CP0In;
        m_ti = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_cmp();
    chk("req", {31'b0, Req}, {31'b0, exp_req()});
    chk($sformatf("rd%0d", CP0Add), CP0Out, exp_rd(CP0Add));
    chk("epc_out", EPCOut, reset ? m_epc : 32'd0);
    chk("timer_irq", {31'b0, TimerIRQ}, {31'b0, m_ti});
  endtask

  task automatic tick();
    @(negedge clk);
    model_cmp();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    en = 0; ExcCodeIn = 0; EXLClr = 0; CP0Add = a;
    #1 chk(name, CP0Out, exp);
    tick();
  endtask

  initial begin
    reset = 0; en = 0; CP0Add = 0; CP0In = 0; VPC = 0; BDIn = 0;
    ExcCodeIn = 0; BadVAddrIn = 0; HWInt = 0; EXLClr = 0;
    repeat (3) tick();
    reset = 1;
    rd(5'd15, 32'h0000_0008, "prid");
    rd(5'd12, 32'd0, "sr_rst");
    rd(5'd13, 32'd0, "cause_rst");
    rd(5'd14, 32'd0, "epc_rst");
    repeat (5) tick();
    CP0Add = 5'd9; ExcCodeIn = 5'd12; reset = 0;
    #1 chk("req_in_rst", {31'b0, Req}, 32'd0);
    chk("count_in_rst", CP0Out, 32'd0);
    tick();
    ExcCodeIn = 0; reset = 1;
    rd(5'd9, 32'd0, "count_after_rst");
    rd(5'd8, 32'd0, "bad_rst");
    // hardware interrupt taken from a delay slot
    en = 1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
    tick();
    en = 0; HWInt = 5'b00001; VPC = 32'h3008; BDIn = 1;
    #1 chk("int_req", {31'b0, Req}, 32'd1);
    tick();
    BDIn = 0;
    #1 chk("int_masked", {31'b0, Req}, 32'd0);
    chk("int_epc_out", EPCOut, 32'h3004);
    rd(5'd14, 32'h3004, "epc_int");
    rd(5'd13, 32'h8000_0400, "cause_int");
    rd(5'd12, 32'h0000_0403, "sr_int");
    // eret re-exposes the pending line
    EXLClr = 1; VPC = 32'h3020;
    tick();
    EXLClr = 0;
    #1 chk("eret_req", {31'b0, Req}, 32'd1);
    tick();
    rd(5'd13, 32'h0000_0400, "cause_eret");
    HWInt = 0;
    en = 1; CP0Add = 5'd14; CP0In = 32'h1237;
    tick();
    rd(5'd14, 32'h1234, "epc_wr");
    en = 1; CP0Add = 5'd10; CP0In = 32'hFFFF_FFFF;
    tick();
    rd(5'd10, 32'd0, "unmapped");
    // AdEL exception with a discarded mtc0 to EPC
    EXLClr = 1;
    tick();
    EXLClr = 0; ExcCodeIn = 5'd4; BadVAddrIn = 32'h1003; VPC = 32'h3010;
    en = 1; CP0Add = 5'd14; CP0In = 32'h5550;
    #1 chk("exc_req", {31'b0, Req}, 32'd1);
    tick();
    rd(5'd14, 32'h3010, "epc_exc");
    rd(5'd8, 32'h1003, "bad_exc");
    rd(5'd13, 32'h0000_0010, "cause_exc");
    EXLClr = 1; en = 1; CP0Add = 5'd12; CP0In = 32'h0000_FC03;
    tick();
    rd(5'd12, 32'h0000_FC01, "sr_eret_wr");
    // interrupt and overflow together: interrupt wins
    HWInt = 5'b00100; ExcCodeIn = 5'd12; BadVAddrIn = 32'hDEAD_0000; VPC = 32'h3040;
    #1 chk("both_req", {31'b0, Req}, 32'd1);
    tick();
    ExcCodeIn = 0; HWInt = 0;
    rd(5'd13, 32'h0000_1000, "cause_both");
    rd(5'd8, 32'h1003, "bad_keep");
    rd(5'd14, 32'h3040, "epc_both");
    // timer: Count=0, Compare=5, prescale 2 -> TI ten cycles later
    en = 1; CP0Add = 5'd9; CP0In = 32'd0;
    tick();
    for (int i = 1; i <= 10; i++) begin
      en = i <= 2;
      CP0Add = i == 1 ? 5'd11 : 5'd12;
      CP0In = i == 1 ? 32'd5 : 32'h0000_8001;
      EXLClr = i == 2;
      tick();
      chk($sformatf("ti_%0d", i), {31'b0, TimerIRQ}, {31'b0, i == 10});
    end
    en = 0; EXLClr = 0; VPC = 32'h3080;
    #1 chk("timer_req", {31'b0, Req}, 32'd1);
    tick();
    rd(5'd13, 32'h4000_8000, "cause_ti");
    en = 1; CP0Add = 5'd11; CP0In = 32'd20;
    tick();
    en = 0;
    chk("ti_clr", {31'b0, TimerIRQ}, 32'd0);
    rd(5'd11, 32'd20, "cmp_rd");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
